// File: rtl/cv32e40p_ex_wb_pipeline.sv
// EX/WB stage for the LSU write-back path: tracks one outstanding data access,
// writes load responses to the register file and flags LSU protocol errors.
module cv32e40p_ex_wb_pipeline #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic        data_req_ex_i,
  input  logic        data_we_ex_i,
  input  logic        data_split_first_i,
  input  logic        regfile_we_ex_i,
  input  logic [5:0]  regfile_waddr_ex_i,
  input  logic        lsu_rvalid_i,
  input  logic [31:0] lsu_rdata_i,
  output logic        wb_ready_o,
  output logic        regfile_we_wb_o,
  output logic [5:0]  regfile_waddr_wb_o,
  output logic [31:0] regfile_wdata_wb_o,
  output logic        wb_busy_o,
  output logic        protocol_err_o
);

  localparam int unsigned AddrW = 6;
  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 16;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WAIT_NOWR = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AddrW-1:0]  pend_waddr_q, pend_waddr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_d;
  logic [AddrW-1:0]  waddr_d;
  logic [DataW-1:0]  wdata_d;
  logic              busy_d;
  logic              err_d;
  logic              accept;
  logic              is_load;

  // EX may hand over a new instruction whenever nothing is pending or the pending one completes now
  assign wb_ready_o = (state_q == IDLE) || lsu_rvalid_i;
  assign accept     = ex_valid_i && wb_ready_o;
  assign is_load    = regfile_we_ex_i && !data_we_ex_i && !data_split_first_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      pend_waddr_q       <= '0;
      cnt_q              <= '0;
      regfile_we_wb_o    <= 1'b0;
      regfile_waddr_wb_o <= '0;
      regfile_wdata_wb_o <= '0;
      wb_busy_o          <= 1'b0;
      protocol_err_o     <= 1'b0;
    end else begin
      state_q            <= state_d;
      pend_waddr_q       <= pend_waddr_d;
      cnt_q              <= cnt_d;
      regfile_we_wb_o    <= we_d;
      regfile_waddr_wb_o <= waddr_d;
      regfile_wdata_wb_o <= wdata_d;
      wb_busy_o          <= busy_d;
      protocol_err_o     <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_waddr_d = pend_waddr_q;
    cnt_d        = cnt_q;
    we_d         = 1'b0;
    waddr_d      = regfile_waddr_wb_o;
    wdata_d      = regfile_wdata_wb_o;
    err_d        = protocol_err_o;

    case (state_q)
      IDLE: begin
        if (lsu_rvalid_i) err_d = 1'b1;
      end
      WAIT_LOAD, WAIT_NOWR: begin
        if (lsu_rvalid_i) begin
          if (state_q == WAIT_LOAD) begin
            we_d    = 1'b1;
            waddr_d = pend_waddr_q;
            wdata_d = lsu_rdata_i;
          end
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != TimeoutVal) begin
          // Saturate at the limit; the error is raised on the edge the limit is reached
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == TimeoutVal) err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A memory request accepted this cycle overrides the return to IDLE
    if (accept && data_req_ex_i) begin
      pend_waddr_d = regfile_waddr_ex_i;
      state_d      = is_load ? WAIT_LOAD : WAIT_NOWR;
      cnt_d        = '0;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_cv32e40p_ex_wb_pipeline.sv
// Directed self-checking bench for cv32e40p_ex_wb_pipeline (TIMEOUT_CYCLES=4).
module tb_cv32e40p_ex_wb_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic        data_req_ex_i = 1'b0;
  logic        data_we_ex_i = 1'b0;
  logic        data_split_first_i = 1'b0;
  logic        regfile_we_ex_i = 1'b0;
  logic [5:0]  regfile_waddr_ex_i = '0;
  logic        lsu_rvalid_i = 1'b0;
  logic [31:0] lsu_rdata_i = '0;
  logic        wb_ready_o;
  logic        regfile_we_wb_o;
  logic [5:0]  regfile_waddr_wb_o;
  logic [31:0] regfile_wdata_wb_o;
  logic        wb_busy_o;
  logic        protocol_err_o;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  cv32e40p_ex_wb_pipeline #(.TIMEOUT_CYCLES(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .ex_valid_i         (ex_valid_i),
    .data_req_ex_i      (data_req_ex_i),
    .data_we_ex_i       (data_we_ex_i),
    .data_split_first_i (data_split_first_i),
    .regfile_we_ex_i    (regfile_we_ex_i),
    .regfile_waddr_ex_i (regfile_waddr_ex_i),
    .lsu_rvalid_i       (lsu_rvalid_i),
    .lsu_rdata_i        (lsu_rdata_i),
    .wb_ready_o         (wb_ready_o),
    .regfile_we_wb_o    (regfile_we_wb_o),
    .regfile_waddr_wb_o (regfile_waddr_wb_o),
    .regfile_wdata_wb_o (regfile_wdata_wb_o),
    .wb_busy_o          (wb_busy_o),
    .protocol_err_o     (protocol_err_o)
  );

  always #5 clk = ~clk;

  // Count write pulses, one sample per cycle
  always @(negedge clk) if (regfile_we_wb_o === 1'b1) wr_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic req, input logic we, input logic split,
                       input logic rfwe, input logic [5:0] addr);
    ex_valid_i = 1'b1; data_req_ex_i = req; data_we_ex_i = we;
    data_split_first_i = split; regfile_we_ex_i = rfwe; regfile_waddr_ex_i = addr;
  endtask

  task automatic idle_ex();
    ex_valid_i = 1'b0; data_req_ex_i = 1'b0; data_we_ex_i = 1'b0;
    data_split_first_i = 1'b0; regfile_we_ex_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; lsu_rvalid_i = 1'b0; idle_ex();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (wb_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", wb_ready_o); end
    checks++; if ({regfile_we_wb_o, wb_busy_o, protocol_err_o} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {regfile_we_wb_o, wb_busy_o, protocol_err_o}); end
    checks++; if ({regfile_waddr_wb_o, regfile_wdata_wb_o} !== 38'd0) begin errors++; $display("FAIL rst_wb got %h/%h exp 0/0", regfile_waddr_wb_o, regfile_wdata_wb_o); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_load();
    int w0;
    w0 = wr_cnt;
    // ALU-only instruction: accepted, no state change
    offer(1'b0, 1'b0, 1'b0, 1'b1, 6'd3);
    step();
    checks++; if (wb_busy_o !== 1'b0) begin errors++; $display("FAIL alu_busy got %b exp 0", wb_busy_o); end
    offer(1'b1, 1'b0, 1'b0, 1'b1, 6'd5);
    step();
    idle_ex();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({wb_ready_o, wb_busy_o} !== 2'b01) begin errors++; $display("FAIL load_wait%0d got %b exp 01", i, {wb_ready_o, wb_busy_o}); end
      step();
    end
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hDEADBEEF;
    #1;
    checks++; if (wb_ready_o !== 1'b1) begin errors++; $display("FAIL load_rsp_ready got %b exp 1", wb_ready_o); end
    step();
    lsu_rvalid_i = 1'b0;
    checks++; if ({regfile_we_wb_o, regfile_waddr_wb_o, regfile_wdata_wb_o} !== {1'b1, 6'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL load_write got %b/%0d/%h exp 1/5/deadbeef", regfile_we_wb_o, regfile_waddr_wb_o, regfile_wdata_wb_o); end
    checks++; if ({wb_busy_o, protocol_err_o} !== 2'b00) begin errors++; $display("FAIL load_idle got %b exp 00", {wb_busy_o, protocol_err_o}); end
    step();
    checks++; if ({regfile_we_wb_o, regfile_waddr_wb_o, regfile_wdata_wb_o} !== {1'b0, 6'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL load_hold got %b/%0d/%h exp 0/5/deadbeef", regfile_we_wb_o, regfile_waddr_wb_o, regfile_wdata_wb_o); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL load_wrcnt got %0d exp 1", wr_cnt - w0); end
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wr_cnt;
    offer(1'b1, 1'b1, 1'b0, 1'b0, 6'd3);
    step();
    idle_ex();
    step();
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h0BAD0BAD;
    offer(1'b1, 1'b0, 1'b0, 1'b1, 6'd7);
    #1;
    checks++; if (wb_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", wb_ready_o); end
    step();
    idle_ex(); lsu_rvalid_i = 1'b0;
    checks++; if ({regfile_we_wb_o, wb_busy_o} !== 2'b01) begin errors++; $display("FAIL b2b_store_nowrite got %b exp 01", {regfile_we_wb_o, wb_busy_o}); end
    step();
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h00000777;
    step();
    lsu_rvalid_i = 1'b0;
    checks++; if ({regfile_we_wb_o, regfile_waddr_wb_o, regfile_wdata_wb_o} !== {1'b1, 6'd7, 32'h777}) begin errors++; $display("FAIL b2b_write got %b/%0d/%h exp 1/7/777", regfile_we_wb_o, regfile_waddr_wb_o, regfile_wdata_wb_o); end
    step();
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL b2b_wrcnt got %0d exp 1", wr_cnt - w0); end
  endtask

  task automatic test_split();
    int w0;
    w0 = wr_cnt;
    offer(1'b1, 1'b0, 1'b1, 1'b1, 6'd9);
    step();
    checks++; if (wb_busy_o !== 1'b1) begin errors++; $display("FAIL split_busy0 got %b exp 1", wb_busy_o); end
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h11;
    offer(1'b1, 1'b0, 1'b0, 1'b1, 6'd9);
    step();
    idle_ex(); lsu_rvalid_i = 1'b0;
    checks++; if ({regfile_we_wb_o, wb_busy_o} !== 2'b01) begin errors++; $display("FAIL split_first got %b exp 01", {regfile_we_wb_o, wb_busy_o}); end
    step();
    checks++; if (wb_busy_o !== 1'b1) begin errors++; $display("FAIL split_busy2 got %b exp 1", wb_busy_o); end
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h22;
    step();
    lsu_rvalid_i = 1'b0;
    checks++; if ({regfile_we_wb_o, regfile_waddr_wb_o, regfile_wdata_wb_o, wb_busy_o} !== {1'b1, 6'd9, 32'h22, 1'b0}) begin errors++; $display("FAIL split_write got %b/%0d/%h/%b exp 1/9/22/0", regfile_we_wb_o, regfile_waddr_wb_o, regfile_wdata_wb_o, wb_busy_o); end
    step();
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL split_wrcnt got %0d exp 1", wr_cnt - w0); end
  endtask

  task automatic test_idle_rvalid();
    int w0;
    w0 = wr_cnt;
    checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL idle_err_pre got %b exp 0", protocol_err_o); end
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h55;
    step();
    lsu_rvalid_i = 1'b0;
    checks++; if ({protocol_err_o, regfile_we_wb_o} !== 2'b10) begin errors++; $display("FAIL idle_err got %b exp 10", {protocol_err_o, regfile_we_wb_o}); end
    step(); step();
    checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL idle_err_sticky got %b exp 1", protocol_err_o); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL idle_wrcnt got %0d exp 0", wr_cnt - w0); end
  endtask

  task automatic test_timeout();
    offer(1'b1, 1'b0, 1'b0, 1'b1, 6'd12);
    step();
    idle_ex();
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL tmo_early%0d got %b exp 0", i, protocol_err_o); end
    end
    step();
    checks++; if ({protocol_err_o, wb_busy_o} !== 2'b11) begin errors++; $display("FAIL tmo_err got %b exp 11", {protocol_err_o, wb_busy_o}); end
    step(); step();
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hCAFEF00D;
    step();
    lsu_rvalid_i = 1'b0;
    checks++; if ({regfile_we_wb_o, regfile_waddr_wb_o, regfile_wdata_wb_o, protocol_err_o} !== {1'b1, 6'd12, 32'hCAFEF00D, 1'b1}) begin errors++; $display("FAIL tmo_write got %b/%0d/%h/%b exp 1/12/cafef00d/1", regfile_we_wb_o, regfile_waddr_wb_o, regfile_wdata_wb_o, protocol_err_o); end
    step();
  endtask

  task automatic test_reset_mid();
    int w0;
    offer(1'b1, 1'b0, 1'b0, 1'b1, 6'd20);
    step();
    idle_ex();
    step();
    checks++; if (wb_busy_o !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b exp 1", wb_busy_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({wb_ready_o, wb_busy_o, protocol_err_o, regfile_we_wb_o} !== 4'b1000) begin errors++; $display("FAIL rmid_async got %b exp 1000", {wb_ready_o, wb_busy_o, protocol_err_o, regfile_we_wb_o}); end
    checks++; if ({regfile_waddr_wb_o, regfile_wdata_wb_o} !== 38'd0) begin errors++; $display("FAIL rmid_wb got %h/%h exp 0/0", regfile_waddr_wb_o, regfile_wdata_wb_o); end
    step();
    rst = 1'b0;
    w0 = wr_cnt;
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h12345678;
    step();
    lsu_rvalid_i = 1'b0;
    checks++; if ({protocol_err_o, regfile_we_wb_o, wb_busy_o} !== 3'b100) begin errors++; $display("FAIL rmid_late got %b exp 100", {protocol_err_o, regfile_we_wb_o, wb_busy_o}); end
    step();
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL rmid_wrcnt got %0d exp 0", wr_cnt - w0); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_split();
    test_idle_rvalid();
    do_reset();
    test_timeout();
    do_reset();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
